// File: rtl/serial_sub_pkg.sv
// Shared types and the full-subtractor equation for the bit-serial subtractor.
// Used by serial_subtractor and full_subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   // One-bit a - b - bi; returns {difference, borrow-out}.
   function automatic logic [1:0] fsub(input logic a, input logic b, input logic bi);
      logic d;
      logic bo;
      d  = a ^ b ^ bi;
      bo = (~a & b) | (~(a ^ b) & bi);
      return {d, bo};
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor cell: d = a - b - bin, bout = borrow.
module full_subtractor
   import serial_sub_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign {d, bout} = fsub(a, b, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin, LSB first) with valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_nxt;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
   logic             borrow;
   logic             cell_d;
   logic             cell_bo;
   logic             accept;
   logic             last_bit;

   assign accept   = (state == IDLE) && in_valid;
   assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);

   full_subtractor u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (borrow),
      .d    (cell_d),
      .bout (cell_bo)
   );

   // Result bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
   always_comb begin
      res_nxt            = res_sr >> 1;
      res_nxt[WIDTH-1]   = cell_d;
   end

   // ------------------------------------------------------------------ FSM
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_valid)          state_nxt = SHIFT;
         SHIFT:   if (cnt == CNT_LAST)   state_nxt = DONE;
         DONE:    if (out_ready)         state_nxt = IDLE;
         default:                        state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // ------------------------------------------------------------- datapath
   // NOTE: shift registers are reset too, so an aborted operation leaves no stale partial result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         borrow <= 1'b0;
         diff_q <= '0;
         bout_q <= 1'b0;
      end else begin
         if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
         end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            borrow <= cell_bo;
            res_sr <= res_nxt;
            cnt    <= cnt + CW'(1);
         end
         // Output registers only change on the final bit, so diff holds through IDLE and SHIFT.
         if (last_bit) begin
            diff_q <= res_nxt;
            bout_q <= cell_bo;
         end
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
   logic a_msb;
   logic b_msb;
   logic ovf_q;

   // Operand sign bits are shifted out during SHIFT, so keep copies from acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         if (accept) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
         end
         if (last_bit) ovf_q <= (a_msb ^ b_msb) & (a_msb ^ res_nxt[WIDTH-1]);
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances).
// Overflow checks are included when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] a, b, diff;
   logic         bin, bout, ovf;

   logic         w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready;
   logic [0:0]   w1_a, w1_b, w1_diff;
   logic         w1_bin, w1_bout, w1_ovf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
      , .ovf(ovf)
`endif
   );

   serial_subtractor #(.WIDTH(1)) u_dut_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
      .a(w1_a), .b(w1_b), .bin(w1_bin), .out_valid(w1_out_valid), .out_ready(w1_out_ready),
      .diff(w1_diff), .bout(w1_bout)
`ifdef SERIAL_SUB_OVF_EN
      , .ovf(w1_ovf)
`endif
   );

`ifndef SERIAL_SUB_OVF_EN
   assign ovf    = 1'b0;
   assign w1_ovf = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on n-bit operands.
   function automatic int ref_diff(int n, int x, int y, int bi);
      return (x - y - bi) & ((1 << n) - 1);
   endfunction

   function automatic int ref_bout(int x, int y, int bi);
      return (x < y + bi) ? 1 : 0;
   endfunction

   function automatic int ref_ovf(int n, int x, int y, int bi);
      int half, sx, sy, r;
      half = 1 << (n - 1);
      sx   = (x >= half) ? x - (1 << n) : x;
      sy   = (y >= half) ? y - (1 << n) : y;
      r    = sx - sy - bi;
      return (r < -half || r > half - 1) ? 1 : 0;
   endfunction

   // Full transaction on the WIDTH=8 instance with `stall` cycles of backpressure in DONE.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                         input int stall);
      int lat;
      int ed, eb;
      ed = ref_diff(W, int'(ta), int'(tb_v), int'(tbin));
      eb = ref_bout(int'(ta), int'(tb_v), int'(tbin));
      @(posedge clk); #1;
      check("in_ready_idle", 32'(in_ready), 32'd1);
      a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      check("in_ready_shift", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(W));
      check("diff", 32'(diff), 32'(ed));
      check("bout", 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
      check("ovf", 32'(ovf), 32'(ref_ovf(W, int'(ta), int'(tb_v), int'(tbin))));
`endif
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
         @(posedge clk); #1;
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_ready", 32'(in_ready), 32'd0);
         check("stall_diff", 32'(diff), 32'(ed));
         check("stall_bout", 32'(bout), 32'(eb));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("release_valid", 32'(out_valid), 32'd0);
      check("release_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic run_op_w1(input logic ta, input logic tb_v, input logic tbin);
      int lat;
      @(posedge clk); #1;
      w1_a = ta; w1_b = tb_v; w1_bin = tbin; w1_in_valid = 1'b1;
      @(posedge clk); #1;
      w1_in_valid = 1'b0;
      lat = 0;
      while (!w1_out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check("w1_latency", 32'(lat), 32'd1);
      check("w1_diff", 32'(w1_diff), 32'(ref_diff(1, int'(ta), int'(tb_v), int'(tbin))));
      check("w1_bout", 32'(w1_bout), 32'(ref_bout(int'(ta), int'(tb_v), int'(tbin))));
`ifdef SERIAL_SUB_OVF_EN
      check("w1_ovf", 32'(w1_ovf), 32'(ref_ovf(1, int'(ta), int'(tb_v), int'(tbin))));
`endif
      w1_out_ready = 1'b1;
      @(posedge clk); #1;
      w1_out_ready = 1'b0;
      check("w1_release", 32'(w1_in_ready), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
      w1_in_valid = 1'b0; w1_out_ready = 1'b0; w1_a = '0; w1_b = '0; w1_bin = 1'b0;
      #2;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      #10 rst_n = 1'b1;

      // Directed cases
      run_op(8'h05, 8'h03, 1'b0, 0);
      run_op(8'h03, 8'h05, 1'b0, 0);
      run_op(8'h00, 8'h00, 1'b1, 0);
      run_op(8'hFF, 8'hFF, 1'b0, 0);
      run_op(8'h80, 8'h01, 1'b0, 0);
      run_op(8'h7F, 8'hFF, 1'b0, 0);
      run_op(8'hA5, 8'h5A, 1'b1, 5);

      // Reset in the middle of SHIFT aborts; the prior non-zero diff must be cleared.
      run_op(8'h05, 8'h03, 1'b0, 0);
      @(posedge clk); #1;
      a = 8'h3C; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_diff", 32'(diff), 32'd0);
      check("abort_bout", 32'(bout), 32'd0);
      #2 rst_n = 1'b1;
      run_op(8'h10, 8'h01, 1'b0, 0);

      // Randomized operands and backpressure
      for (int i = 0; i < 16; i++)
         run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

      // WIDTH=1 instance: every operand combination
      run_op_w1(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++)
         run_op_w1(1'(i >> 2), 1'(i >> 1), 1'(i));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
